serializador: RTL and testbench

Upstream byte-to-bit sender for the `deserializador` input stage. It accepts bytes over a valid/ready handshake into a one-entry holding register and shifts each byte out MSB-first on `data_out`, one bit per `clk_100KHz` cycle with `write_out` high. It stalls whenever the deserializer's `status_out` (wired to `status_in`) is high, and inserts a programmable idle gap between bytes.

---
 rtl/serializador.sv | 114 +++++++++++
 tb/tb_serializador.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializador.sv
// Byte-to-bit sender: one-entry holding register, MSB-first shift-out with
// downstream back-pressure (status_in) and a programmable inter-byte gap.
module serializador #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk_100KHz,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       status_in,
  output logic       data_out,
  output logic       write_out,
  output logic       busy,
  output logic [7:0] sent_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES);

  state_e     state_q;
  logic       hold_full_q, hold_full_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] sr_q;
  logic [2:0] bit_cnt_q;
  logic [3:0] gap_cnt_q;
  logic       write_q, data_q;
  logic [7:0] sent_q;
  logic       accept, load;

  assign accept = byte_valid & ~hold_full_q;
  assign load   = (state_q == IDLE) & hold_full_q & ~status_in;

  // accept and load are mutually exclusive (opposite hold_full_q conditions)
  always_comb begin
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    if (load)   hold_full_d = 1'b0;
    if (accept) begin
      hold_full_d = 1'b1;
      hold_d      = byte_in;
    end
  end

  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      hold_full_q <= 1'b0;
      hold_q      <= 8'h00;
    end else begin
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
    end
  end

  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      gap_cnt_q <= 4'd0;
      write_q   <= 1'b0;
      data_q    <= 1'b0;
      sent_q    <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          write_q <= 1'b0;
          if (load) begin
            sr_q      <= hold_q;
            bit_cnt_q <= 3'd0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (status_in) begin
            write_q <= 1'b0;
          end else begin
            write_q   <= 1'b1;
            data_q    <= sr_q[7];
            sr_q      <= {sr_q[6:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sent_q    <= sent_q + 8'd1;
              gap_cnt_q <= 4'd0;
              state_q   <= GAP;
            end
          end
        end
        GAP: begin
          // GAP spans GAP_CYCLES+1 cycles so a byte slot is 10+GAP_CYCLES long
          write_q   <= 1'b0;
          gap_cnt_q <= gap_cnt_q + 4'd1;
          if (gap_cnt_q == GAP_LAST) state_q <= IDLE;
        end
        default: begin
          write_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign byte_ready = ~hold_full_q;
  assign busy       = (state_q != IDLE) | hold_full_q;
  assign data_out   = data_q;
  assign write_out  = write_q;
  assign sent_count = sent_q;

endmodule

// File: tb/tb_serializador.sv
// Bench for serializador: directed scenarios on a GAP=1 and a GAP=3 instance,
// with a slot-timeline reference model compared every cycle.
module tb_serializador;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] bin[2];
  logic       bval[2], stin[2];
  logic       bready[2], dout[2], wout[2], busy[2];
  logic [7:0] scnt[2];

  serializador #(.GAP_CYCLES(1)) dut0 (
    .clk_100KHz(clk), .reset(rst_n), .byte_in(bin[0]), .byte_valid(bval[0]),
    .byte_ready(bready[0]), .status_in(stin[0]), .data_out(dout[0]),
    .write_out(wout[0]), .busy(busy[0]), .sent_count(scnt[0]));

  serializador #(.GAP_CYCLES(3)) dut1 (
    .clk_100KHz(clk), .reset(rst_n), .byte_in(bin[1]), .byte_valid(bval[1]),
    .byte_ready(bready[1]), .status_in(stin[1]), .data_out(dout[1]),
    .write_out(wout[1]), .busy(busy[1]), .sent_count(scnt[1]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: a loaded byte owns a timeline of 8 bit slots (each consumed
  // only on a non-stalled cycle) followed by GAP+1 silent slots.
  bit       m_act[2], m_hold[2], m_w[2], m_d[2];
  bit [7:0] m_hreg[2], m_byte[2], m_cnt[2];
  int       m_idx[2];

  task automatic step(input int i);
    bit acc;
    int g;
    g   = (i == 0) ? 1 : 3;
    acc = (bval[i] === 1'b1) && !m_hold[i];
    if (!m_act[i]) begin
      m_w[i] = 1'b0;
      if (m_hold[i] && stin[i] !== 1'b1) begin
        m_act[i]  = 1'b1;
        m_byte[i] = m_hreg[i];
        m_idx[i]  = 0;
        m_hold[i] = 1'b0;
      end
    end else if (m_idx[i] < 8) begin
      if (stin[i] === 1'b1) m_w[i] = 1'b0;
      else begin
        m_w[i] = 1'b1;
        m_d[i] = m_byte[i][7 - m_idx[i]];
        m_idx[i]++;
        if (m_idx[i] == 8) m_cnt[i]++;
      end
    end else begin
      m_w[i] = 1'b0;
      m_idx[i]++;
      if (m_idx[i] == 9 + g) m_act[i] = 1'b0;
    end
    if (acc) begin
      m_hold[i] = 1'b1;
      m_hreg[i] = bin[i];
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 0; m_hold[i] = 0; m_w[i] = 0; m_d[i] = 0;
        m_hreg[i] = 0; m_byte[i] = 0; m_cnt[i] = 0; m_idx[i] = 0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) step(i);
    end
  end

  int rise1[$];
  bit pw1 = 1'b0;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.write_out", i), wout[i], m_w[i]);
      chk($sformatf("u%0d.data_out", i), dout[i], m_d[i]);
      chk($sformatf("u%0d.byte_ready", i), bready[i], !m_hold[i]);
      chk($sformatf("u%0d.busy", i), busy[i], m_act[i] | m_hold[i]);
      chk($sformatf("u%0d.sent_count", i), scnt[i], m_cnt[i]);
    end
    if (wout[1] === 1'b1 && !pw1) rise1.push_back(cyc);
    pw1 = (wout[1] === 1'b1);
  end

  task automatic send0(input logic [7:0] b);
    bin[0] = b; bval[0] = 1'b1;
    @(negedge clk);
    bval[0] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (busy[i] !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d.drain", i), busy[i], 1'b0);
  endtask

  task automatic collect0(input int nbits, output logic [7:0] got);
    int nb, n;
    nb = 0; n = 0; got = 8'h00;
    while (nb < nbits && n < 60) begin
      @(negedge clk);
      n++;
      if (wout[0] === 1'b1) begin
        got = {got[6:0], dout[0]};
        nb++;
      end
    end
    chk("collect.bits", nb, nbits);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [7:0] pat, got;
    int t0, t1, tf, tl, nb, n;
    for (int i = 0; i < 2; i++) begin
      bin[i] = 8'h00; bval[i] = 1'b0; stin[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.byte_ready", bready[0], 1'b1);
    chk("rst.busy", busy[0], 1'b0);
    chk("rst.write_out", wout[0], 1'b0);
    chk("rst.data_out", dout[0], 1'b0);
    chk("rst.sent_count", scnt[0], 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single byte 0xA5
    send0(8'hA5);
    chk("a5.ready_after_accept", bready[0], 1'b0);
    @(negedge clk);
    chk("a5.load_edge_write", wout[0], 1'b0);
    pat = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("a5.write[%0d]", k), wout[0], 1'b1);
      chk($sformatf("a5.bit[%0d]", k), dout[0], pat[7 - k]);
    end
    chk("a5.sent_count", scnt[0], 8'd1);
    @(negedge clk);
    chk("a5.busy_e10", busy[0], 1'b1);
    @(negedge clk);
    chk("a5.busy_e11", busy[0], 1'b0);

    // back-to-back 0x00 then 0xFF
    send0(8'h00);
    @(negedge clk);
    chk("b2b.ready_after_load", bready[0], 1'b1);
    bin[0] = 8'hFF; bval[0] = 1'b1;
    @(negedge clk);
    bval[0] = 1'b0;
    t0 = cyc;
    chk("b2b.first_write", wout[0], 1'b1);
    chk("b2b.first_bit", dout[0], 1'b0);
    n = 0;
    while (!(wout[0] === 1'b1 && dout[0] === 1'b1) && n < 30) begin
      @(negedge clk);
      n++;
      if (cyc == t0 + 9)  chk("b2b.ready_before_load", bready[0], 1'b0);
      if (cyc == t0 + 10) chk("b2b.ready_after_load2", bready[0], 1'b1);
    end
    t1 = cyc;
    chk("b2b.first_bit_spacing", t1 - t0, 11);
    wait_idle(0);

    // stall of 3 cycles inside 0x3C
    send0(8'h3C);
    nb = 0; n = 0; got = 8'h00; tf = 0; tl = 0;
    while (nb < 8 && n < 60) begin
      @(negedge clk);
      n++;
      if (wout[0] === 1'b1) begin
        got = {got[6:0], dout[0]};
        if (nb == 0) tf = cyc;
        nb++;
        tl = cyc;
        if (nb == 4) begin
          stin[0] = 1'b1;
          repeat (3) begin
            @(negedge clk);
            chk("stall.write_low", wout[0], 1'b0);
            chk("stall.data_frozen", dout[0], got[0]);
          end
          stin[0] = 1'b0;
        end
      end
    end
    chk("stall.bits", got, 8'h3C);
    chk("stall.span", tl - tf, 10);
    wait_idle(0);

    // back-pressure while IDLE with a byte held
    stin[0] = 1'b1;
    send0(8'h5A);
    repeat (3) begin
      @(negedge clk);
      chk("idlestall.busy", busy[0], 1'b1);
      chk("idlestall.ready", bready[0], 1'b0);
      chk("idlestall.write", wout[0], 1'b0);
    end
    stin[0] = 1'b0;
    @(negedge clk);
    chk("idlestall.load_ready", bready[0], 1'b1);
    chk("idlestall.load_write", wout[0], 1'b0);
    @(negedge clk);
    chk("idlestall.first_write", wout[0], 1'b1);
    chk("idlestall.first_bit", dout[0], 1'b0);
    wait_idle(0);

    // asynchronous reset mid-byte
    send0(8'hF8);
    collect0(5, got);
    chk("arst.pre_data", dout[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.write_out", wout[0], 1'b0);
    chk("arst.data_out", dout[0], 1'b0);
    chk("arst.byte_ready", bready[0], 1'b1);
    chk("arst.busy", busy[0], 1'b0);
    chk("arst.sent_count", scnt[0], 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send0(8'h81);
    collect0(8, got);
    chk("arst.resend_bits", got, 8'h81);
    wait_idle(0);
    chk("arst.sent_count_after", scnt[0], 8'd1);

    // 256 bytes on the GAP=3 instance, holding register kept full
    for (int b = 0; b < 256; b++) begin
      n = 0;
      while (bready[1] !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      bin[1] = b[7:0]; bval[1] = 1'b1;
      @(negedge clk);
      bval[1] = 1'b0;
    end
    wait_idle(1);
    chk("wrap.sent_count", scnt[1], 8'd0);
    chk("wrap.bytes_seen", rise1.size(), 256);
    chk("wrap.period_a", (rise1.size() > 20) ? rise1[20] - rise1[19] : -1, 13);
    chk("wrap.period_b", (rise1.size() > 200) ? rise1[200] - rise1[199] : -1, 13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
